// File: rtl/lsu_unit.sv
// Memory-stage load/store unit.
// Takes a decoded load or store and runs it on a word-addressed req/gnt/rvalid
// data bus. An access that straddles a word boundary is issued as two word
// transactions. Load data goes back sign- or zero-extended. The pipeline is
// stalled from the accept cycle until the done pulse.
module lsu_unit #(
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        sl_op_i,
    input  logic              ls_unsign_i,
    input  logic              mem_wren_i,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_n_s;

    // Decode of the incoming request, consumed on the accept cycle.
    logic [1:0]        off_in_s;
    logic [7:0]        be8_in_s;
    logic [63:0]       wd64_in_s;
    logic              split_in_s;
    logic              legal_in_s;
    logic              err_in_s;
    logic              accept_s;

    // Per-access context held until the access completes.
    logic [1:0]        off_r;
    logic [3:0]        sl_op_r;
    logic              unsign_r;
    logic              wren_r;
    logic              split_r;
    logic              err_r;
    logic [3:0]        be_hi_r;
    logic [31:0]       wd_hi_r;
    logic [31:0]       rd0_r;

    // Next-cycle values for the registered outputs.
    logic              req_n_s;
    logic              we_n_s;
    logic [ADDR_W-1:0] addr_n_s;
    logic [3:0]        be_n_s;
    logic [31:0]       wdata_n_s;
    logic [31:0]       rd0_n_s;
    logic [31:0]       rdata_n_s;
    logic              err_n_s;

    // Shift a two-word read window down by the byte offset, then pick and
    // extend the lanes that the access size asks for.
    function automatic logic [31:0] load_ext(
        input logic [63:0] win,
        input logic [1:0]  off,
        input logic [3:0]  sl_op,
        input logic        uns
    );
        logic [63:0] r64;
        logic [31:0] res;
        r64 = win >> {off, 3'b000};
        case (sl_op)
            4'b0001: res = uns ? {24'h000000, r64[7:0]}  : {{24{r64[7]}}, r64[7:0]};
            4'b0011: res = uns ? {16'h0000, r64[15:0]}   : {{16{r64[15]}}, r64[15:0]};
            4'b1111: res = r64[31:0];
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Lane placement and legality check for the request presented this cycle.
    always_comb begin
        off_in_s   = addr_i[1:0];
        be8_in_s   = {4'b0000, sl_op_i} << off_in_s;
        wd64_in_s  = {32'h0000_0000, wdata_i} << {off_in_s, 3'b000};
        split_in_s = |be8_in_s[7:4];
        legal_in_s = (sl_op_i == 4'b0001) || (sl_op_i == 4'b0011) || (sl_op_i == 4'b1111);
        err_in_s   = !legal_in_s || (split_in_s && !MISALIGN_EN);
        accept_s   = req_valid_i && ready_o;
    end

    // Next state and next bus/result values. Bus fields hold by default, so a
    // request stays stable for as long as the grant is withheld.
    always_comb begin
        state_n_s = state_r;
        req_n_s   = dmem_req_o;
        we_n_s    = dmem_we_o;
        addr_n_s  = dmem_addr_o;
        be_n_s    = dmem_be_o;
        wdata_n_s = dmem_wdata_o;
        rd0_n_s   = rd0_r;
        rdata_n_s = 32'h0000_0000;
        err_n_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    // An illegal access still passes through REQ0 but never raises a request.
                    state_n_s = REQ0;
                    req_n_s   = !err_in_s;
                    we_n_s    = mem_wren_i && !err_in_s;
                    addr_n_s  = {addr_i[ADDR_W-1:2], 2'b00};
                    be_n_s    = be8_in_s[3:0];
                    wdata_n_s = wd64_in_s[31:0];
                end else begin
                    req_n_s   = 1'b0;
                end
            end
            REQ0: begin
                if (err_r) begin
                    state_n_s = DONE;
                    err_n_s   = 1'b1;
                end else if (dmem_gnt_i) begin
                    state_n_s = WAIT0;
                    req_n_s   = 1'b0;
                end else begin
                    state_n_s = REQ0;
                end
            end
            WAIT0: begin
                if (dmem_rvalid_i) begin
                    rd0_n_s = dmem_rdata_i;
                    if (split_r) begin
                        state_n_s = REQ1;
                        req_n_s   = 1'b1;
                        addr_n_s  = dmem_addr_o + ADDR_W'(3'd4);
                        be_n_s    = be_hi_r;
                        wdata_n_s = wd_hi_r;
                    end else begin
                        state_n_s = DONE;
                        rdata_n_s = wren_r ? 32'h0000_0000
                                  : load_ext({32'h0000_0000, dmem_rdata_i}, off_r, sl_op_r, unsign_r);
                    end
                end else begin
                    state_n_s = WAIT0;
                end
            end
            REQ1: begin
                if (dmem_gnt_i) begin
                    state_n_s = WAIT1;
                    req_n_s   = 1'b0;
                end else begin
                    state_n_s = REQ1;
                end
            end
            WAIT1: begin
                if (dmem_rvalid_i) begin
                    state_n_s = DONE;
                    rdata_n_s = wren_r ? 32'h0000_0000
                              : load_ext({dmem_rdata_i, rd0_r}, off_r, sl_op_r, unsign_r);
                end else begin
                    state_n_s = WAIT1;
                end
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
                req_n_s   = 1'b0;
            end
        endcase
    end

    // State register plus every registered output, all derived from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            ready_o      <= 1'b1;
            stall_o      <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            rdata_o      <= 32'h0000_0000;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 4'b0000;
            dmem_wdata_o <= 32'h0000_0000;
            rd0_r        <= 32'h0000_0000;
        end else begin
            state_r      <= state_n_s;
            ready_o      <= (state_n_s == IDLE);
            stall_o      <= (state_n_s != IDLE);
            done_o       <= (state_n_s == DONE);
            err_o        <= err_n_s;
            rdata_o      <= rdata_n_s;
            dmem_req_o   <= req_n_s;
            dmem_we_o    <= we_n_s;
            dmem_addr_o  <= addr_n_s;
            dmem_be_o    <= be_n_s;
            dmem_wdata_o <= wdata_n_s;
            rd0_r        <= rd0_n_s;
        end
    end

    // Capture the access context on acceptance; hold it for the whole access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            off_r    <= 2'b00;
            sl_op_r  <= 4'b0000;
            unsign_r <= 1'b0;
            wren_r   <= 1'b0;
            split_r  <= 1'b0;
            err_r    <= 1'b0;
            be_hi_r  <= 4'b0000;
            wd_hi_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            off_r    <= off_in_s;
            sl_op_r  <= sl_op_i;
            unsign_r <= ls_unsign_i;
            wren_r   <= mem_wren_i;
            split_r  <= split_in_s;
            err_r    <= err_in_s;
            be_hi_r  <= be8_in_s[7:4];
            wd_hi_r  <= wd64_in_s[63:32];
        end else begin
            off_r    <= off_r;
            sl_op_r  <= sl_op_r;
            unsign_r <= unsign_r;
            wren_r   <= wren_r;
            split_r  <= split_r;
            err_r    <= err_r;
            be_hi_r  <= be_hi_r;
            wd_hi_r  <= wd_hi_r;
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit. The main instance (misaligned splitting on)
// talks to a small word memory with adjustable grant delay. A second instance
// with splitting off gets an always-granting bus and is used for the
// misaligned-error response.
module tb_lsu_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sl_op;
    logic        ls_unsign;
    logic        mem_wren;

    logic        ready, done, err, stall;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        gnt, rvalid;
    logic [31:0] rbus;

    logic        d2_ready, d2_done, d2_err, d2_stall, d2_req, d2_we, d2_rv;
    logic [31:0] d2_rdata, d2_addr, d2_wdata;
    logic [3:0]  d2_be;

    lsu_unit #(.ADDR_W(32), .MISALIGN_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .ready_o(ready),
        .addr_i(addr), .wdata_i(wdata), .sl_op_i(sl_op), .ls_unsign_i(ls_unsign),
        .mem_wren_i(mem_wren), .done_o(done), .rdata_o(rdata), .err_o(err),
        .stall_o(stall), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rbus)
    );

    lsu_unit #(.ADDR_W(32), .MISALIGN_EN(1'b0)) dut_na (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .ready_o(d2_ready),
        .addr_i(addr), .wdata_i(wdata), .sl_op_i(sl_op), .ls_unsign_i(ls_unsign),
        .mem_wren_i(mem_wren), .done_o(d2_done), .rdata_o(d2_rdata), .err_o(d2_err),
        .stall_o(d2_stall), .dmem_req_o(d2_req), .dmem_we_o(d2_we),
        .dmem_addr_o(d2_addr), .dmem_be_o(d2_be), .dmem_wdata_o(d2_wdata),
        .dmem_gnt_i(1'b1), .dmem_rvalid_i(d2_rv), .dmem_rdata_i(32'h0000_0000)
    );

    // Second instance: every request is granted at once and answered next cycle.
    always @(posedge clk) d2_rv <= d2_req;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus model state.
    logic [31:0] mem [0:255];
    logic [31:0] log_addr  [0:3];
    logic [31:0] log_wdata [0:3];
    logic [3:0]  log_be    [0:3];
    logic        log_we    [0:3];
    int          log_n, req_cycles, unstable, bad_stall, gnt_delay, wait_left;
    bit          pend_rv, hold_rv, in_req;
    logic [31:0] pend_data;
    logic [68:0] snap;

    // Memory-side responder, driven on the falling edge.
    always @(negedge clk) begin
        rvalid = 1'b0;
        if (pend_rv && !hold_rv) begin
            rvalid  = 1'b1;
            rbus    = pend_data;
            pend_rv = 1'b0;
        end
        gnt = 1'b0;
        if (dmem_req) begin
            req_cycles++;
            if (!stall || ready) bad_stall++;
            if (!in_req) snap = {dmem_addr, dmem_be, dmem_wdata, dmem_we};
            else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== snap) unstable++;
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                gnt = 1'b1;
                if (log_n < 4) begin
                    log_addr[log_n] = dmem_addr; log_be[log_n] = dmem_be;
                    log_wdata[log_n] = dmem_wdata; log_we[log_n] = dmem_we;
                    log_n++;
                end
                if (dmem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (dmem_be[b]) mem[dmem_addr[9:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                end
                pend_data = mem[dmem_addr[9:2]];
                pend_rv   = 1'b1;
                wait_left = gnt_delay;
            end
        end
        in_req = dmem_req;
    end

    int          lat_g, d2_lat_g, d2_req_g;
    logic [31:0] rd_g;
    logic        err_g, d2_err_g;

    // One access on both instances; latency counted in cycles after acceptance.
    task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] op,
                             input logic uns, input logic we);
        log_n = 0; req_cycles = 0;
        lat_g = 0; d2_lat_g = 0; d2_req_g = 0; rd_g = 32'h0; err_g = 1'b0; d2_err_g = 1'b0;
        @(posedge clk); #1;
        chk("ready_before_accept", ready, 1'b1);
        addr = a; wdata = wd; sl_op = op; ls_unsign = uns; mem_wren = we; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (d2_req) d2_req_g++;
            if (d2_done && d2_lat_g == 0) begin d2_lat_g = k; d2_err_g = d2_err; end
            if (done) begin lat_g = k; rd_g = rdata; err_g = err; break; end
            @(posedge clk); #1;
        end
        if (lat_g == 0) chk("done_timeout", done, 1'b1);
        @(posedge clk); #1;
        chk("done_one_pulse", {done, err, rdata, ready}, {1'b0, 1'b0, 32'h0, 1'b1});
    endtask

    int stale_done;

    initial begin
        rst = 1'b1; req_valid = 1'b0; addr = 32'h0; wdata = 32'h0; sl_op = 4'h0;
        ls_unsign = 1'b0; mem_wren = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rbus = 32'h0;
        gnt_delay = 0; wait_left = 0; hold_rv = 1'b0; pend_rv = 1'b0; in_req = 1'b0;
        unstable = 0; bad_stall = 0; log_n = 0; req_cycles = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'h1234_5678;
        mem[8'h40] = 32'h80FF_1234;
        mem[8'h80] = 32'h5A00_0000;
        mem[8'h81] = 32'h0000_00A5;

        repeat (2) @(posedge clk); #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_ctl", {stall, done, err, dmem_req, dmem_we, dmem_be}, 64'h0);
        chk("rst_addr_wdata", {dmem_addr, dmem_wdata}, 64'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_d2", {d2_ready, d2_stall, d2_done, d2_err, d2_req, d2_we, d2_be, d2_rdata}, {1'b1, 41'h0});
        chk("rst_d2_bus", {d2_addr, d2_wdata}, 64'h0);
        rst = 1'b0;

        // LB / LBU from the top byte of word 0x100
        do_access(32'h103, 32'h0, 4'b0001, 1'b0, 1'b0);
        chk("lb_lat", lat_g, 3);
        chk("lb_rdata", rd_g, 32'hFFFF_FF80);
        chk("lb_err", err_g, 1'b0);
        chk("lb_ntxn", log_n, 1);
        chk("lb_bus", {log_addr[0], log_be[0], log_we[0]}, {32'h100, 4'b1000, 1'b0});
        do_access(32'h103, 32'h0, 4'b0001, 1'b1, 1'b0);
        chk("lbu_lat", lat_g, 3);
        chk("lbu_rdata", rd_g, 32'h0000_0080);

        // misaligned SW splits into two writes
        do_access(32'h102, 32'hAABB_CCDD, 4'b1111, 1'b0, 1'b1);
        chk("sw_lat", lat_g, 5);
        chk("sw_rdata", rd_g, 32'h0);
        chk("sw_ntxn", log_n, 2);
        chk("sw_t0", {log_addr[0], log_be[0], log_we[0]}, {32'h100, 4'b1100, 1'b1});
        chk("sw_t0_wdata", log_wdata[0], 32'hCCDD_0000);
        chk("sw_t1", {log_addr[1], log_be[1], log_we[1]}, {32'h104, 4'b0011, 1'b1});
        chk("sw_t1_wdata", log_wdata[1], 32'h0000_AABB);
        chk("sw_noalign_err", {d2_lat_g[7:0], d2_err_g, d2_req_g[7:0]}, {8'd2, 1'b1, 8'd0});

        // misaligned LH / LHU across words 0x200 and 0x204
        do_access(32'h203, 32'h0, 4'b0011, 1'b0, 1'b0);
        chk("lh_lat", lat_g, 5);
        chk("lh_rdata", rd_g, 32'hFFFF_A55A);
        do_access(32'h203, 32'h0, 4'b0011, 1'b1, 1'b0);
        chk("lhu_rdata", rd_g, 32'h0000_A55A);

        // grant withheld for five cycles
        gnt_delay = 5; wait_left = 5; unstable = 0; bad_stall = 0;
        do_access(32'h100, 32'h0, 4'b1111, 1'b0, 1'b0);
        chk("bp_lat", lat_g, 8);
        chk("bp_rdata", rd_g, 32'hCCDD_1234);
        chk("bp_req_cycles", req_cycles, 6);
        chk("bp_stable", unstable, 0);
        chk("bp_stall_ready", bad_stall, 0);
        gnt_delay = 0; wait_left = 0;

        // illegal lane mask
        do_access(32'h100, 32'h0, 4'b0101, 1'b0, 1'b0);
        chk("ill_lat", lat_g, 2);
        chk("ill_err", err_g, 1'b1);
        chk("ill_rdata", rd_g, 32'h0);
        chk("ill_noreq", req_cycles, 0);

        // LW at 0x101: split on main, error on the non-splitting instance
        do_access(32'h101, 32'h0, 4'b1111, 1'b0, 1'b0);
        chk("lw_mis_rdata", rd_g, 32'hBBCC_DD12);
        chk("lw_mis_lat", lat_g, 5);
        chk("lw_mis_noalign", {d2_lat_g[7:0], d2_err_g, d2_req_g[7:0]}, {8'd2, 1'b1, 8'd0});

        // reset while waiting for read data
        hold_rv = 1'b1;
        @(posedge clk); #1;
        addr = 32'h0; sl_op = 4'b1111; ls_unsign = 1'b0; mem_wren = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rw_req0", dmem_req, 1'b1);
        @(posedge clk); #1;
        chk("rw_wait0", {stall, dmem_req}, {1'b1, 1'b0});
        rst = 1'b1;
        #1;
        chk("rw_reset_out", {ready, stall, done, err, dmem_req, dmem_we, dmem_be}, {1'b1, 9'h0});
        @(posedge clk); #1;
        rst = 1'b0; hold_rv = 1'b0;
        stale_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || !ready) stale_done++;
        end
        chk("stale_rvalid_ignored", stale_done, 0);

        do_access(32'h000, 32'h0, 4'b1111, 1'b0, 1'b0);
        chk("lw0_lat", lat_g, 3);
        chk("lw0_rdata", rd_g, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
